// File: rtl/mario_pkg.sv
// Shared Mario types and physics defaults.
// Used by vertical/horizontal motion and sprite logic.
package mario_pkg;

    localparam int COORD_W = 13;

    typedef enum logic [1:0] {
        GROUNDED,
        RISING,
        FALLING
    } mario_state_e;

    localparam logic [COORD_W-1:0] DEF_START_Y  = 13'd384;
    localparam logic [COORD_W-1:0] DEF_MIN_Y    = 13'd0;
    localparam logic [COORD_W-1:0] DEF_JUMP_V   = 13'd12;
    localparam logic [COORD_W-1:0] DEF_GRAVITY  = 13'd1;
    localparam logic [COORD_W-1:0] DEF_MAX_FALL = 13'd10;
    localparam logic [4:0]         DEF_HOLD     = 5'd12;

endpackage

// File: rtl/frame_tick.sv
// Synchronises the vsync-rate frame strobe into the Clk domain
// and emits a single-cycle tick on each rising edge.
module frame_tick (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    output logic tick
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], frame_clk};
            prev_q <= sync_q[1];
        end
    end

    assign tick = sync_q[1] & ~prev_q;

endmodule

// File: rtl/mario_vertical_motion.sv
// Per-frame vertical physics for Mario: jump, gravity,
// landing snap and ceiling clamp, closed-loop with the detector.
module mario_vertical_motion
    import mario_pkg::*;
#(
    parameter logic [COORD_W-1:0] START_Y          = DEF_START_Y,
    parameter logic [COORD_W-1:0] MIN_Y            = DEF_MIN_Y,
    parameter logic [COORD_W-1:0] JUMP_V           = DEF_JUMP_V,
    parameter logic [COORD_W-1:0] GRAVITY          = DEF_GRAVITY,
    parameter logic [COORD_W-1:0] MAX_FALL         = DEF_MAX_FALL,
    parameter logic [4:0]         JUMP_HOLD_FRAMES = DEF_HOLD
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               jump_key,
    input  logic               Respawn,
    input  logic               is_in_air,
    input  logic [COORD_W-1:0] level,
    output logic [COORD_W-1:0] Mario_Y_Pos,
    output logic [COORD_W-1:0] Mario_Y_Motion,
    output logic               Mario_Airborne
);

    logic tick;

    frame_tick u_frame_tick (
        .clk       (Clk),
        .reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    mario_state_e       state_q, state_d;
    logic [COORD_W-1:0] y_d, m_d;
    logic [4:0]         hold_q, hold_d;
    logic               armed_q, armed_d;

    logic [COORD_W-1:0] sum13;
    logic [COORD_W-1:0] m_grav;
    logic [COORD_W-1:0] fall_v;
    logic signed [COORD_W:0] ceil_sum;
    logic               ceil_hit;
    logic               launch;

    assign sum13    = Mario_Y_Pos + Mario_Y_Motion;
    assign ceil_sum = $signed({1'b0, Mario_Y_Pos})
                    + $signed({Mario_Y_Motion[COORD_W-1], Mario_Y_Motion});
    assign ceil_hit = ceil_sum < $signed({1'b0, MIN_Y});
    assign m_grav   = Mario_Y_Motion + GRAVITY;
    assign fall_v   = ($signed(m_grav) > $signed(MAX_FALL)) ? MAX_FALL : m_grav;
    assign launch   = (state_q == GROUNDED) && jump_key && armed_q;

    always_comb begin
        state_d = state_q;
        y_d     = Mario_Y_Pos;
        m_d     = Mario_Y_Motion;
        hold_d  = hold_q;
        armed_d = armed_q;
        if (tick) begin
            unique case (state_q)
                GROUNDED: begin
                    if (launch) begin
                        m_d     = '0 - JUMP_V;
                        hold_d  = '0;
                        state_d = RISING;
                    end else if (is_in_air) begin
                        m_d     = GRAVITY;
                        state_d = FALLING;
                    end else begin
                        y_d = level;
                        m_d = '0;
                    end
                end
                RISING: begin
                    if (ceil_hit) begin
                        y_d     = MIN_Y;
                        m_d     = '0;
                        state_d = FALLING;
                    end else begin
                        y_d = sum13;
                        if (jump_key && hold_q < JUMP_HOLD_FRAMES) begin
                            hold_d = hold_q + 5'd1;
                        end else begin
                            m_d = m_grav;
                            if (!m_grav[COORD_W-1]) state_d = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (!is_in_air) begin
                        y_d     = level;
                        m_d     = '0;
                        state_d = GROUNDED;
                    end else begin
                        y_d = sum13;
                        m_d = fall_v;
                    end
                end
                default: state_d = GROUNDED;
            endcase
            // A held key must be released on some tick before the next jump
            if (launch) armed_d = 1'b0;
            else if (!jump_key) armed_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || Respawn) begin
            state_q        <= GROUNDED;
            Mario_Y_Pos    <= START_Y;
            Mario_Y_Motion <= '0;
            Mario_Airborne <= 1'b0;
            hold_q         <= '0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            Mario_Y_Pos    <= y_d;
            Mario_Y_Motion <= m_d;
            Mario_Airborne <= (state_d != GROUNDED);
            hold_q         <= hold_d;
            armed_q        <= armed_d;
        end
    end

endmodule

// File: tb/tb_mario_vertical_motion.sv
// Directed + randomized bench for mario_vertical_motion with an
// integer physics model and a simple floor detector in the loop.
module tb_mario_vertical_motion;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        jump_key = 1'b0;
    logic        Respawn = 1'b0;
    logic        is_in_air = 1'b0;
    logic [12:0] level = 13'd384;
    logic [12:0] Mario_Y_Pos;
    logic [12:0] Mario_Y_Motion;
    logic        Mario_Airborne;

    localparam logic [12:0] NEG12 = 13'h1FF4;

    mario_vertical_motion dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .jump_key       (jump_key),
        .Respawn        (Respawn),
        .is_in_air      (is_in_air),
        .level          (level),
        .Mario_Y_Pos    (Mario_Y_Pos),
        .Mario_Y_Motion (Mario_Y_Motion),
        .Mario_Airborne (Mario_Airborne)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // model: mode 0 = on ground, 1 = going up, 2 = coming down
    int my, mm, mode, hold, armed, floor_y;

    task automatic chk(input string tag, input logic [12:0] obs,
                       input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_y"}, Mario_Y_Pos, 13'(my));
        chk({tag, "_m"}, Mario_Y_Motion, 13'(mm));
        chk({tag, "_air"}, {12'b0, Mario_Airborne}, {12'b0, mode != 0});
    endtask

    task automatic model_reset();
        my = 384; mm = 0; mode = 0; hold = 0; armed = 0;
    endtask

    task automatic model_step(input bit key, input bit air, input int lvl);
        if (mode == 0) begin
            if (key && armed == 1) begin
                mm = -12; hold = 0; mode = 1; armed = 0;
            end else if (air) begin
                mm = 1; mode = 2;
            end else begin
                my = lvl; mm = 0;
            end
        end else if (mode == 1) begin
            if (my + mm < 0) begin
                my = 0; mm = 0; mode = 2;
            end else begin
                my = my + mm;
                if (key && hold < 12) hold++;
                else begin
                    mm++;
                    if (mm >= 0) mode = 2;
                end
            end
        end else begin
            if (!air) begin
                my = lvl; mm = 0; mode = 0;
            end else begin
                my = (my + mm) % 8192;
                mm = (mm + 1 > 10) ? 10 : mm + 1;
            end
        end
        if (!key) armed = 1;
    endtask

    task automatic tick(input bit key, input bit resp, input string tag);
        bit air;
        air = (((my + mm) % 8192 + 8192) % 8192) < floor_y;
        @(negedge Clk);
        jump_key  = key;
        is_in_air = air;
        level     = 13'(floor_y);
        Respawn   = resp;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        Respawn   = 1'b0;
        repeat (3) @(negedge Clk);
        if (resp) model_reset();
        else model_step(key, air, floor_y);
        check_model(tag);
    endtask

    initial begin
        floor_y = 384;
        model_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_y", Mario_Y_Pos, 13'd384);
        chk("rst_m", Mario_Y_Motion, 13'd0);
        chk("rst_air", {12'b0, Mario_Airborne}, 13'd0);
        repeat (3) tick(0, 0, "idle");
        chk("idle_y", Mario_Y_Pos, 13'd384);

        // jump tap
        tick(1, 0, "tap_launch");
        chk("tap_launch_m", Mario_Y_Motion, NEG12);
        for (int i = 0; i < 30 && mode == 1; i++) tick(0, 0, "tap_rise");
        chk("tap_apex_y", Mario_Y_Pos, 13'd306);
        chk("tap_apex_m", Mario_Y_Motion, 13'd0);
        chk("tap_apex_air", {12'b0, Mario_Airborne}, 13'd1);
        for (int i = 0; i < 40 && mode != 0; i++) tick(0, 0, "tap_fall");
        chk("tap_land_y", Mario_Y_Pos, 13'd384);
        chk("tap_land_air", {12'b0, Mario_Airborne}, 13'd0);

        // jump held throughout
        tick(0, 0, "hold_arm");
        tick(1, 0, "hold_launch");
        repeat (12) tick(1, 0, "hold_rise");
        chk("hold12_y", Mario_Y_Pos, 13'd240);
        chk("hold12_m", Mario_Y_Motion, NEG12);
        for (int i = 0; i < 30 && mode == 1; i++) tick(1, 0, "hold_decel");
        chk("hold_apex_y", Mario_Y_Pos, 13'd162);
        for (int i = 0; i < 60 && mode != 0; i++) tick(1, 0, "hold_fall");
        repeat (3) tick(1, 0, "hold_norejump");
        chk("norejump_y", Mario_Y_Pos, 13'd384);
        chk("norejump_air", {12'b0, Mario_Airborne}, 13'd0);
        tick(0, 0, "rearm");
        tick(1, 0, "rejump");
        chk("rejump_m", Mario_Y_Motion, NEG12);
        for (int i = 0; i < 80 && mode != 0; i++) tick(0, 0, "rejump_air");

        // walk off ledge, fall saturation, landing snap
        floor_y = 100;
        tick(0, 0, "snap100");
        chk("snap100_y", Mario_Y_Pos, 13'd100);
        floor_y = 256;
        tick(0, 0, "walkoff");
        chk("walkoff_y", Mario_Y_Pos, 13'd100);
        chk("walkoff_m", Mario_Y_Motion, 13'd1);
        chk("walkoff_air", {12'b0, Mario_Airborne}, 13'd1);
        for (int i = 0; i < 20 && mm < 10; i++) tick(0, 0, "accel");
        chk("maxfall_m", Mario_Y_Motion, 13'd10);
        tick(0, 0, "maxfall_hold");
        chk("maxfall_hold_m", Mario_Y_Motion, 13'd10);
        for (int i = 0; i < 30 && mode != 0; i++) tick(0, 0, "to256");
        chk("land256_y", Mario_Y_Pos, 13'd256);
        chk("land256_m", Mario_Y_Motion, 13'd0);

        // ceiling clamp
        floor_y = 5;
        tick(0, 0, "snap5");
        tick(1, 0, "ceil_launch");
        tick(1, 0, "ceil_hit");
        chk("ceil_y", Mario_Y_Pos, 13'd0);
        chk("ceil_m", Mario_Y_Motion, 13'd0);
        chk("ceil_air", {12'b0, Mario_Airborne}, 13'd1);
        floor_y = 384;
        for (int i = 0; i < 80 && mode != 0; i++) tick(0, 0, "ceil_fall");

        // respawn coincident with a tick while rising
        tick(0, 0, "rsp_arm");
        tick(1, 0, "rsp_launch");
        tick(1, 0, "rsp_rise");
        tick(1, 1, "respawn");
        chk("respawn_y", Mario_Y_Pos, 13'd384);
        chk("respawn_air", {12'b0, Mario_Airborne}, 13'd0);
        tick(1, 0, "rsp_unarmed");

        // reset together with respawn and a tick
        tick(0, 0, "rr_arm");
        tick(1, 0, "rr_launch");
        tick(1, 0, "rr_rise");
        @(negedge Clk);
        Reset = 1'b1; Respawn = 1'b1; frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0; Respawn = 1'b0;
        model_reset();
        chk("rr_y", Mario_Y_Pos, 13'd384);
        chk("rr_m", Mario_Y_Motion, 13'd0);
        chk("rr_air", {12'b0, Mario_Airborne}, 13'd0);

        // randomized play
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 4))
                    0: floor_y = 384;
                    1: floor_y = 300;
                    2: floor_y = 200;
                    3: floor_y = 100;
                    default: floor_y = 40;
                endcase
            end
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                 "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
